// File: rtl/jtag_ir_decode.sv
// JTAG instruction register with capture/shift/update, one-hot instruction decode
// and a valid/ready handoff of each newly updated instruction to the debug core.
module jtag_ir_decode #(
  parameter int                          width        = 8,
  parameter int                          NUM_INSTR    = 4,
  parameter logic [NUM_INSTR*width-1:0]  INSTR_LIST   = {8'h08, 8'h04, 8'h02, 8'h01},
  parameter logic [width-1:0]            RESET_INSTR  = 8'h01,
  parameter logic [width-1:0]            BYPASS_INSTR = {width{1'b1}}
) (
  input  logic                 iclk,
  input  logic                 reset,
  input  logic                 test_logic_reset,
  input  logic                 clk_ir,
  input  logic                 capture_ir,
  input  logic                 shift_ir,
  input  logic                 update_ir,
  input  logic                 s_data_in,
  output logic                 s_data_out,
  input  logic [width-1:0]     p_data_in,
  output logic [width-1:0]     p_data_out,
  output logic [NUM_INSTR-1:0] instr_sel,
  output logic                 bypass_sel,
  output logic                 upd_valid,
  input  logic                 upd_ready,
  output logic                 upd_overrun
);

  logic [width-1:0] sr;
  logic [width-1:0] ir;
  logic [width-1:0] capture_val;
  logic             clear;

  // Returns {bypass, one-hot select}; the lowest matching list index wins and the
  // explicit BYPASS opcode never selects a list entry.
  function automatic logic [NUM_INSTR:0] decode(input logic [width-1:0] op);
    logic [NUM_INSTR-1:0] sel;
    logic                 hit;
    sel = '0;
    hit = 1'b0;
    if (op != BYPASS_INSTR) begin
      for (int i = 0; i < NUM_INSTR; i++) begin
        if (!hit && op == INSTR_LIST[i*width +: width]) begin
          sel[i] = 1'b1;
          hit    = 1'b1;
        end
      end
    end
    return {~hit, sel};
  endfunction

  // Status lands in the upper bits; the two LSBs are the mandatory 01 pattern.
  always_comb begin
    capture_val      = p_data_in;
    capture_val[1:0] = 2'b01;
  end

  assign clear      = !reset || test_logic_reset;
  assign s_data_out = sr[0];
  assign p_data_out = ir;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values (e.g. ir takes sr before this edge's shift).
  always_ff @(posedge iclk) begin
    if (clear) begin
      sr                      <= RESET_INSTR;
      ir                      <= RESET_INSTR;
      {bypass_sel, instr_sel} <= decode(RESET_INSTR);
      upd_valid               <= 1'b0;
      upd_overrun             <= 1'b0;
    end else begin
      if (clk_ir && capture_ir) begin
        sr <= capture_val;
      end else if (clk_ir && shift_ir) begin
        sr <= {s_data_in, sr[width-1:1]};
      end

      upd_overrun <= update_ir && upd_valid && !upd_ready;

      if (update_ir) begin
        ir                      <= sr;
        {bypass_sel, instr_sel} <= decode(sr);
        upd_valid               <= 1'b1;
      end else if (upd_ready) begin
        upd_valid <= 1'b0;
      end
    end
  end

endmodule
